eth_rx_app_fifo: RTL and testbench

// - Store-and-forward payload buffer downstream of the eth_rx app_* outputs.
// - Holds each UDP payload frame until it is complete, then releases it to the application over a valid/ready stream.
// - A frame that is cancelled (phy cancel) or overflows is rolled back and never reaches the reader.

---
 rtl/eth_rx_app_fifo_if.sv | 27 ++
 rtl/eth_rx_app_fifo.sv | 145 ++++++++++++++
 tb/tb_eth_rx_app_fifo.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_app_fifo_if.sv
// Payload-in and committed-beat-out streams of eth_rx_app_fifo.
// master: the side feeding app_* and draining rd_*; slave: the FIFO.
interface eth_rx_app_fifo_if #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = $clog2(DATA_W/8 + 1)
);
  logic              app_valid_i;
  logic              app_start_i;
  logic              app_cancel_i;
  logic [DATA_W-1:0] app_data_i;
  logic [LEN_W-1:0]  app_len_i;
  logic              rd_valid_o;
  logic              rd_ready_i;
  logic [DATA_W-1:0] rd_data_o;
  logic [LEN_W-1:0]  rd_len_o;
  logic              rd_last_o;

  modport master (
    output app_valid_i, app_start_i, app_cancel_i, app_data_i, app_len_i, rd_ready_i,
    input  rd_valid_o, rd_data_o, rd_len_o, rd_last_o
  );

  modport slave (
    input  app_valid_i, app_start_i, app_cancel_i, app_data_i, app_len_i, rd_ready_i,
    output rd_valid_o, rd_data_o, rd_len_o, rd_last_o
  );
endinterface

// File: rtl/eth_rx_app_fifo.sv
// Store-and-forward payload FIFO: frames become readable only once committed; cancelled or
// overflowing frames are rolled back. ETH_RX_APP_FIFO_STATS_EN adds frame/drop counters.
module eth_rx_app_fifo #(
  parameter int DATA_W   = 16,
  parameter int LEN_W    = $clog2(DATA_W/8 + 1),
  parameter int DEPTH    = 64,
  parameter int IDLE_CYC = 4
) (
  input  logic             clk,
  input  logic             nreset,
  eth_rx_app_fifo_if.slave bus,
  output logic             drop_o
`ifdef ETH_RX_APP_FIFO_STATS_EN
  ,
  output logic [31:0]      frm_cnt_o,
  output logic [31:0]      drop_cnt_o
`endif
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int IW     = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_DROP} state_t;

  state_t                    state, state_nxt;
  logic [PW-1:0]             wr_ptr, cm_ptr, rd_ptr, wr_nxt, cm_nxt, used;
  logic [IW-1:0]             idle_cnt, idle_nxt;
  logic [DATA_W+LEN_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]          last;
  logic                      drop_nxt, we, set_old, set_new, full, pending, rd_fire;
  logic                      nz, short_beat;
  logic [1:0]                n_commit;
  logic [AW-1:0]             wr_idx, wr_m1_idx, rd_idx;

  assign used       = wr_ptr - rd_ptr;
  assign full       = (used == PW'(DEPTH));
  assign pending    = (wr_ptr != cm_ptr);
  assign wr_idx     = wr_ptr[AW-1:0];
  assign wr_m1_idx  = wr_idx - AW'(1);
  assign rd_idx     = rd_ptr[AW-1:0];
  assign nz         = (bus.app_len_i != '0);
  assign short_beat = (bus.app_len_i < LEN_W'(KEEP_W));

  assign bus.rd_valid_o = (cm_ptr != rd_ptr);
  assign rd_fire        = bus.rd_valid_o && bus.rd_ready_i;
  assign {bus.rd_data_o, bus.rd_len_o} = mem[rd_idx];
  assign bus.rd_last_o  = last[rd_idx];

  always_comb begin
    state_nxt = state;
    wr_nxt    = wr_ptr;
    cm_nxt    = cm_ptr;
    idle_nxt  = idle_cnt;
    drop_nxt  = 1'b0;
    we        = 1'b0;
    set_old   = 1'b0;
    set_new   = 1'b0;
    n_commit  = '0;
    if (bus.app_cancel_i) begin
      if (state == S_OPEN) begin
        wr_nxt    = cm_ptr;
        drop_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
    end else if (state == S_OPEN && !bus.app_valid_i) begin
      if (idle_cnt == IDLE_LAST) begin
        state_nxt = S_IDLE;
        if (pending) begin
          set_old  = 1'b1;
          cm_nxt   = wr_ptr;
          n_commit = 2'd1;
        end
      end else begin
        idle_nxt = idle_cnt + IW'(1);
      end
    end else if (bus.app_valid_i && (bus.app_start_i || state == S_OPEN)) begin
      state_nxt = S_OPEN;
      idle_nxt  = '0;
      // Close the stored part of the frame first; a start beat or len-0 terminator does this.
      if (state == S_OPEN && pending && (bus.app_start_i || !nz)) begin
        set_old  = 1'b1;
        cm_nxt   = wr_ptr;
        n_commit = 2'd1;
      end
      if (nz) begin
        if (full) begin
          wr_nxt    = cm_nxt;
          drop_nxt  = 1'b1;
          state_nxt = S_DROP;
        end else begin
          we     = 1'b1;
          wr_nxt = wr_ptr + PW'(1);
          if (short_beat) begin
            set_new   = 1'b1;
            cm_nxt    = wr_ptr + PW'(1);
            n_commit  = n_commit + 2'd1;
            state_nxt = S_IDLE;
          end
        end
      end else if (!bus.app_start_i) begin
        state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      cm_ptr   <= '0;
      rd_ptr   <= '0;
      idle_cnt <= '0;
      drop_o   <= 1'b0;
      last     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_nxt;
      cm_ptr   <= cm_nxt;
      idle_cnt <= idle_nxt;
      drop_o   <= drop_nxt;
      if (rd_fire) begin
        rd_ptr       <= rd_ptr + PW'(1);
        last[rd_idx] <= 1'b0;
      end
      if (we) mem[wr_idx] <= {bus.app_data_i, bus.app_len_i};
      if (set_old) last[wr_m1_idx] <= 1'b1;
      if (set_new) last[wr_idx] <= 1'b1;
    end
  end

`ifdef ETH_RX_APP_FIFO_STATS_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      frm_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      frm_cnt_o <= frm_cnt_o + 32'(n_commit);
      if (drop_nxt) drop_cnt_o <= drop_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_eth_rx_app_fifo.sv
// Directed bench for eth_rx_app_fifo (DEPTH=4, IDLE_CYC=4, DATA_W=16).
module tb_eth_rx_app_fifo;
  logic clk = 1'b0;
  logic nreset;
  logic drop_o;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   n_drop = 0;
  logic [18:0] q_beat[$];
  int          q_cyc[$];
`ifdef ETH_RX_APP_FIFO_STATS_EN
  logic [31:0] frm_cnt, drop_cnt;
`endif

  eth_rx_app_fifo_if #(.DATA_W(16), .LEN_W(2)) bus ();

  eth_rx_app_fifo #(.DATA_W(16), .LEN_W(2), .DEPTH(4), .IDLE_CYC(4)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus),
    .drop_o (drop_o)
`ifdef ETH_RX_APP_FIFO_STATS_EN
    ,
    .frm_cnt_o  (frm_cnt),
    .drop_cnt_o (drop_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted output beat as {last,len,data} with its cycle number.
  always @(negedge clk) begin
    if (bus.rd_valid_o && bus.rd_ready_i) begin
      q_beat.push_back({bus.rd_last_o, bus.rd_len_o, bus.rd_data_o});
      q_cyc.push_back(cyc);
    end
    if (drop_o) n_drop <= n_drop + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic s, input logic c,
                       input logic [15:0] d, input logic [1:0] l);
    bus.app_valid_i  = v;
    bus.app_start_i  = s;
    bus.app_cancel_i = c;
    bus.app_data_i   = d;
    bus.app_len_i    = l;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 16'h0, 2'd0);
  endtask

  function automatic logic [31:0] bt(input logic lst, input logic [1:0] len, input logic [15:0] d);
    return {13'd0, lst, len, d};
  endfunction

  function automatic logic [31:0] beat_at(input int i);
    if (i < q_beat.size()) return {13'd0, q_beat[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < q_cyc.size()) return q_cyc[i];
    return -100;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int qb, d0, cc;
    logic [31:0] exp1 [4];
    logic [31:0] exp4 [4];
    logic [31:0] exp5 [6];

    nreset = 1'b0;
    bus.rd_ready_i = 1'b0;
    bus.app_valid_i = 1'b0; bus.app_start_i = 1'b0; bus.app_cancel_i = 1'b0;
    bus.app_data_i = '0; bus.app_len_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.rd_valid_o), 32'd0);
    chk("rst_drop",  32'(drop_o), 32'd0);
    chk("rst_data",  32'(bus.rd_data_o), 32'd0);
    chk("rst_len",   32'(bus.rd_len_o), 32'd0);
    chk("rst_last",  32'(bus.rd_last_o), 32'd0);
    nreset = 1'b1;
    idle(2);

    // 1: three full beats plus a 1-byte tail, read continuously
    bus.rd_ready_i = 1'b1;
    qb = q_beat.size();
    drive(1'b1, 1'b1, 1'b0, 16'h1111, 2'd2);
    drive(1'b1, 1'b0, 1'b0, 16'h2222, 2'd2);
    drive(1'b1, 1'b0, 1'b0, 16'h3333, 2'd2);
    chk("t1_hold", 32'(bus.rd_valid_o), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 16'h0044, 2'd1);
    cc = cyc;
    chk("t1_vis", 32'(bus.rd_valid_o), 32'd1);
    idle(6);
    exp1 = '{bt(1'b0, 2'd2, 16'h1111), bt(1'b0, 2'd2, 16'h2222),
             bt(1'b0, 2'd2, 16'h3333), bt(1'b1, 2'd1, 16'h0044)};
    chk("t1_cnt", 32'(q_beat.size() - qb), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_beat%0d", i), beat_at(qb + i), exp1[i]);
    chk("t1_lat", 32'(cyc_at(qb)), 32'(cc));

    // 2: cancel on the third beat, then a cancel while idle
    qb = q_beat.size();
    d0 = n_drop;
    drive(1'b1, 1'b1, 1'b0, 16'hA001, 2'd2);
    drive(1'b1, 1'b0, 1'b0, 16'hA002, 2'd2);
    drive(1'b1, 1'b0, 1'b1, 16'hA003, 2'd2);
    chk("t2_drop", 32'(drop_o), 32'd1);
    idle(1);
    chk("t2_pulse", 32'(drop_o), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 16'h0, 2'd0);
    chk("t2_idle_cancel", 32'(drop_o), 32'd0);
    idle(6);
    chk("t2_nout", 32'(q_beat.size() - qb), 32'd0);
    chk("t2_ndrop", 32'(n_drop - d0), 32'd1);
    chk("t2_valid", 32'(bus.rd_valid_o), 32'd0);

    // 3: overflow a 4-deep FIFO, then deliver a 2-beat frame intact
    bus.rd_ready_i = 1'b0;
    qb = q_beat.size();
    drive(1'b1, 1'b1, 1'b0, 16'hB001, 2'd2);
    drive(1'b1, 1'b0, 1'b0, 16'hB002, 2'd2);
    drive(1'b1, 1'b0, 1'b0, 16'hB003, 2'd2);
    drive(1'b1, 1'b0, 1'b0, 16'hB004, 2'd2);
    chk("t3_nodrop4", 32'(drop_o), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 16'hB005, 2'd2);
    chk("t3_drop5", 32'(drop_o), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 16'hFFFF, 2'd2);
    chk("t3_dropq", 32'(bus.rd_valid_o), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 16'hC001, 2'd2);
    drive(1'b1, 1'b0, 1'b0, 16'h00C2, 2'd1);
    bus.rd_ready_i = 1'b1;
    idle(4);
    chk("t3_cnt", 32'(q_beat.size() - qb), 32'd2);
    chk("t3_beat0", beat_at(qb), bt(1'b0, 2'd2, 16'hC001));
    chk("t3_beat1", beat_at(qb + 1), bt(1'b1, 2'd1, 16'h00C2));

    // 4: idle-timeout commit, then commit triggered by a new start
    bus.rd_ready_i = 1'b0;
    qb = q_beat.size();
    drive(1'b1, 1'b1, 1'b0, 16'hD001, 2'd2);
    drive(1'b1, 1'b0, 1'b0, 16'hD002, 2'd2);
    idle(3);
    chk("t4_idle3", 32'(bus.rd_valid_o), 32'd0);
    idle(1);
    chk("t4_idle4", 32'(bus.rd_valid_o), 32'd1);
    bus.rd_ready_i = 1'b1;
    idle(3);
    bus.rd_ready_i = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 16'hE001, 2'd2);
    drive(1'b1, 1'b0, 1'b0, 16'hE002, 2'd2);
    idle(3);
    chk("t4_pre_start", 32'(bus.rd_valid_o), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 16'hF001, 2'd2);
    chk("t4_start_commit", 32'(bus.rd_valid_o), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 16'h00F2, 2'd1);
    bus.rd_ready_i = 1'b1;
    idle(6);
    exp4 = '{bt(1'b0, 2'd2, 16'hE001), bt(1'b1, 2'd2, 16'hE002),
             bt(1'b0, 2'd2, 16'hF001), bt(1'b1, 2'd1, 16'h00F2)};
    chk("t4_cnt", 32'(q_beat.size() - qb), 32'd6);
    chk("t4_idle_b0", beat_at(qb), bt(1'b0, 2'd2, 16'hD001));
    chk("t4_idle_b1", beat_at(qb + 1), bt(1'b1, 2'd2, 16'hD002));
    for (int i = 0; i < 4; i++) chk($sformatf("t4_beat%0d", i), beat_at(qb + 2 + i), exp4[i]);

    // 5: back-to-back frames while reading continuously
    qb = q_beat.size();
    drive(1'b1, 1'b1, 1'b0, 16'h5A01, 2'd2);
    drive(1'b1, 1'b0, 1'b0, 16'h0002, 2'd1);
    drive(1'b1, 1'b1, 1'b0, 16'h5B01, 2'd2);
    drive(1'b1, 1'b0, 1'b0, 16'h0003, 2'd1);
    drive(1'b1, 1'b1, 1'b0, 16'h5C01, 2'd2);
    drive(1'b1, 1'b0, 1'b0, 16'h0004, 2'd1);
    idle(5);
    exp5 = '{bt(1'b0, 2'd2, 16'h5A01), bt(1'b1, 2'd1, 16'h0002),
             bt(1'b0, 2'd2, 16'h5B01), bt(1'b1, 2'd1, 16'h0003),
             bt(1'b0, 2'd2, 16'h5C01), bt(1'b1, 2'd1, 16'h0004)};
    chk("t5_cnt", 32'(q_beat.size() - qb), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("t5_beat%0d", i), beat_at(qb + i), exp5[i]);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t5_gap%0d", i), 32'(cyc_at(qb + i + 1) - cyc_at(qb + i)), 32'd1);
`ifdef ETH_RX_APP_FIFO_STATS_EN
    chk("t5_frm_cnt", frm_cnt, 32'd8);
    chk("t5_drop_cnt", drop_cnt, 32'd2);
`endif

    // 6: reset mid-frame with two committed frames queued
    bus.rd_ready_i = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 16'h6001, 2'd2);
    idle(4);
    drive(1'b1, 1'b1, 1'b0, 16'h6002, 2'd2);
    drive(1'b1, 1'b0, 1'b0, 16'h0063, 2'd1);
    drive(1'b1, 1'b1, 1'b0, 16'h6004, 2'd2);
    chk("t6_queued", 32'(bus.rd_valid_o), 32'd1);
    bus.app_valid_i = 1'b0; bus.app_start_i = 1'b0;
    nreset = 1'b0;
    #2;
    chk("t6_rst_valid", 32'(bus.rd_valid_o), 32'd0);
    @(posedge clk);
    #1;
    chk("t6_rst_valid_next", 32'(bus.rd_valid_o), 32'd0);
    chk("t6_rst_last", 32'(bus.rd_last_o), 32'd0);
    nreset = 1'b1;
    idle(1);
`ifdef ETH_RX_APP_FIFO_STATS_EN
    chk("t6_frm_rst", frm_cnt, 32'd0);
`endif
    qb = q_beat.size();
    bus.rd_ready_i = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 16'h7001, 2'd2);
    drive(1'b1, 1'b0, 1'b0, 16'h0072, 2'd1);
    idle(4);
    chk("t6_cnt", 32'(q_beat.size() - qb), 32'd2);
    chk("t6_beat0", beat_at(qb), bt(1'b0, 2'd2, 16'h7001));
    chk("t6_beat1", beat_at(qb + 1), bt(1'b1, 2'd1, 16'h0072));
`ifdef ETH_RX_APP_FIFO_STATS_EN
    chk("t6_frm_cnt", frm_cnt, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
